// File: rtl/branch_resolve.sv
// branch_resolve: two-stage branch condition evaluator producing taken/mispredict/redirect
// against an always-taken prediction, with saturating branch and mispredict counters.
module branch_resolve (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_rs1,
  input  logic [31:0] in_rs2,
  input  logic [31:0] in_imm,
  input  logic [2:0]  in_funct3,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_taken,
  output logic        out_mispredict,
  output logic [31:0] out_redirect_pc,
  output logic        out_illegal,
  output logic [31:0] br_count,
  output logic [31:0] mispred_count
);
  logic        r_s1_valid;
  logic [31:0] r_s1_pc, r_s1_rs1, r_s1_rs2, r_s1_imm;
  logic [2:0]  r_s1_funct3;
  logic        r_s2_valid, r_s2_taken, r_s2_mispredict, r_s2_illegal;
  logic [31:0] r_s2_redirect, r_br_count, r_mispred_count;
  logic        w_drain, w_s1_adv, w_accept, w_eq, w_lt, w_ltu, w_illegal, w_taken;
  logic [31:0] w_redirect;

  assign out_valid       = r_s2_valid & !flush;
  assign w_drain         = out_valid & out_ready;
  assign w_s1_adv        = r_s1_valid & (!r_s2_valid | w_drain);
  assign in_ready        = !r_s1_valid | w_s1_adv;
  assign w_accept        = in_valid & in_ready & !flush;
  assign out_taken       = r_s2_taken;
  assign out_mispredict  = r_s2_mispredict;
  assign out_illegal     = r_s2_illegal;
  assign out_redirect_pc = r_s2_redirect;
  assign br_count        = r_br_count;
  assign mispred_count   = r_mispred_count;

  // funct3[0] inverts the base comparison (BNE/BGE/BGEU)
  always_comb begin
    w_eq       = r_s1_rs1 == r_s1_rs2;
    w_lt       = $signed(r_s1_rs1) < $signed(r_s1_rs2);
    w_ltu      = r_s1_rs1 < r_s1_rs2;
    w_illegal  = r_s1_funct3[2:1] == 2'b01;
    w_taken    = r_s1_funct3[2:1] == 2'b00 ? w_eq  ^ r_s1_funct3[0] :
                 r_s1_funct3[2:1] == 2'b10 ? w_lt  ^ r_s1_funct3[0] :
                 r_s1_funct3[2:1] == 2'b11 ? w_ltu ^ r_s1_funct3[0] : 1'b0;
    w_redirect = r_s1_pc + (w_taken ? r_s1_imm : 32'd4);
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_s1_pc     <= in_pc;
      r_s1_rs1    <= in_rs1;
      r_s1_rs2    <= in_rs2;
      r_s1_imm    <= in_imm;
      r_s1_funct3 <= in_funct3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_s1_valid <= 1'b0;
    else if (flush)
      r_s1_valid <= 1'b0;
    else if (w_accept)
      r_s1_valid <= 1'b1;
    else if (w_s1_adv)
      r_s1_valid <= 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid      <= 1'b0;
      r_s2_taken      <= 1'b0;
      r_s2_mispredict <= 1'b0;
      r_s2_illegal    <= 1'b0;
      r_s2_redirect   <= 32'd0;
    end else if (flush) begin
      r_s2_valid <= 1'b0;
    end else if (w_s1_adv) begin
      r_s2_valid      <= 1'b1;
      r_s2_taken      <= w_taken;
      r_s2_mispredict <= !w_taken;
      r_s2_illegal    <= w_illegal;
      r_s2_redirect   <= w_redirect;
    end else if (w_drain) begin
      r_s2_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_br_count      <= 32'd0;
      r_mispred_count <= 32'd0;
    end else if (w_drain) begin
      r_br_count      <= r_br_count + {31'd0, ~&r_br_count};
      r_mispred_count <= r_mispred_count + {31'd0, r_s2_mispredict & ~&r_mispred_count};
    end
  end
endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve: directed and random stimulus checked against an in-order scoreboard
// whose entries become visible two cycles after presentation.
module tb_branch_resolve;
  logic        clk = 1'b0, rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic        out_taken, out_mispredict, out_illegal;
  logic [31:0] in_pc, in_rs1, in_rs2, in_imm, out_redirect_pc, br_count, mispred_count;
  logic [2:0]  in_funct3;

  always #5 clk = ~clk;

  branch_resolve dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_funct3(in_funct3),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_taken(out_taken),
    .out_mispredict(out_mispredict), .out_redirect_pc(out_redirect_pc),
    .out_illegal(out_illegal), .br_count(br_count), .mispred_count(mispred_count)
  );

  typedef struct {logic [31:0] rd; logic tk, mp, il; int acc;} ent_t;
  ent_t        q[$];
  int          ncyc = 0, npass = 0, ntot = 0;
  logic [31:0] br_e = 0, mp_e = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntot++;
    assert (got === exp) npass++;
    else $error("FAIL %s got 0x%08h exp 0x%08h", tag, got, exp);
  endtask

  function automatic ent_t ref_res(input logic [31:0] pc, a, b, imm, input logic [2:0] f3,
                                   input int acc);
    ent_t e;
    logic t;
    case (f3)
      3'd0:    t = a == b;
      3'd1:    t = a != b;
      3'd4:    t = (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000);
      3'd5:    t = !((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000));
      3'd6:    t = a < b;
      3'd7:    t = a >= b;
      default: t = 1'b0;
    endcase
    e.il  = (f3 == 3'd2) || (f3 == 3'd3);
    e.tk  = t;
    e.mp  = !t;
    e.rd  = t ? pc + imm : pc + 32'd4;
    e.acc = acc;
    return e;
  endfunction

  task automatic cyc(input logic iv, input logic [31:0] pc, a, b, imm, input logic [2:0] f3,
                     input logic ordy, input logic fl, output logic acc);
    logic ov_e, hs, ir_e;
    in_valid = iv; in_pc = pc; in_rs1 = a; in_rs2 = b; in_imm = imm; in_funct3 = f3;
    out_ready = ordy; flush = fl;
    #1;
    ov_e = !fl && q.size() > 0 && (ncyc - q[0].acc >= 2);
    hs   = ov_e && ordy;
    ir_e = q.size() < 2 || hs;
    chk("in_ready", {31'd0, in_ready}, {31'd0, ir_e});
    chk("out_valid", {31'd0, out_valid}, {31'd0, ov_e});
    if (ov_e) begin
      chk("out_taken", {31'd0, out_taken}, {31'd0, q[0].tk});
      chk("out_mispredict", {31'd0, out_mispredict}, {31'd0, q[0].mp});
      chk("out_illegal", {31'd0, out_illegal}, {31'd0, q[0].il});
      chk("out_redirect_pc", out_redirect_pc, q[0].rd);
    end
    chk("br_count", br_count, br_e);
    chk("mispred_count", mispred_count, mp_e);
    acc = iv && ir_e && !fl;
    if (hs) begin
      if (br_e != '1) br_e++;
      if (q[0].mp && mp_e != '1) mp_e++;
      void'(q.pop_front());
    end
    if (acc) q.push_back(ref_res(pc, a, b, imm, f3, ncyc));
    if (fl) q.delete();
    @(negedge clk);
    ncyc++;
  endtask

  task automatic idle(input int n);
    logic d;
    for (int i = 0; i < n; i++) cyc(1'b0, 0, 0, 0, 0, 3'd0, 1'b1, 1'b0, d);
  endtask

  task automatic chk_cleared();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_taken", {31'd0, out_taken}, 32'd0);
    chk("rst_out_mispredict", {31'd0, out_mispredict}, 32'd0);
    chk("rst_out_illegal", {31'd0, out_illegal}, 32'd0);
    chk("rst_redirect", out_redirect_pc, 32'd0);
    chk("rst_br_count", br_count, 32'd0);
    chk("rst_mispred_count", mispred_count, 32'd0);
  endtask

  initial begin
    logic        a;
    logic [31:0] b0, ra;
    int          sent;
    rst = 1'b1; in_valid = 1'b1; in_pc = 32'h40; in_rs1 = 0; in_rs2 = 0; in_imm = 0;
    in_funct3 = 3'd0; flush = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk_cleared();
    @(negedge clk);
    chk_cleared();
    rst = 1'b0;
    idle(3);

    cyc(1'b1, 32'h100, 32'hFFFF_FFFF, 32'h1, 32'h20, 3'd4, 1'b1, 1'b0, a);
    idle(3);
    cyc(1'b1, 32'h100, 32'hFFFF_FFFF, 32'h1, 32'h20, 3'd6, 1'b1, 1'b0, a);
    idle(3);
    cyc(1'b1, 32'h300, 32'h5, 32'h5, 32'h40, 3'd2, 1'b1, 1'b0, a);
    cyc(1'b1, 32'h304, 32'h5, 32'h6, 32'h40, 3'd3, 1'b1, 1'b0, a);
    idle(3);
    cyc(1'b1, 32'hFFFF_FFFC, 32'h1234, 32'h1234, 32'h8, 3'd0, 1'b1, 1'b0, a);
    idle(3);

    b0 = br_e;
    sent = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(sent < 4, 32'h200 + 32'(sent) * 4, 32'(sent), 32'h2, 32'h10, 3'd4,
          !(i >= 3 && i <= 5), 1'b0, a);
      if (a) sent++;
    end
    idle(2);
    chk("stream_sent", 32'(sent), 32'd4);
    chk("stream_br_count", br_count, b0 + 32'd4);

    cyc(1'b1, 32'h400, 32'h1, 32'h2, 32'h8, 3'd1, 1'b0, 1'b0, a);
    cyc(1'b1, 32'h404, 32'h1, 32'h2, 32'h8, 3'd0, 1'b0, 1'b0, a);
    cyc(1'b1, 32'h408, 32'h1, 32'h2, 32'h8, 3'd7, 1'b1, 1'b1, a);
    idle(3);

    force dut.r_br_count = 32'hFFFF_FFFE;
    force dut.r_mispred_count = 32'hFFFF_FFFE;
    #1;
    release dut.r_br_count;
    release dut.r_mispred_count;
    br_e = 32'hFFFF_FFFE;
    mp_e = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h500, 32'h9, 32'h3, 32'h8, 3'd6, 1'b1, 1'b0, a);
    idle(4);
    chk("sat_br_count", br_count, 32'hFFFF_FFFF);
    chk("sat_mispred_count", mispred_count, 32'hFFFF_FFFF);

    for (int i = 0; i < 500; i++) begin
      ra = $urandom;
      cyc($urandom_range(0, 3) != 0, $urandom, ra, ($urandom_range(0, 3) == 0) ? ra : $urandom,
          $urandom, 3'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
          $urandom_range(0, 19) == 0, a);
    end

    cyc(1'b1, 32'h600, 32'h1, 32'h1, 32'h8, 3'd0, 1'b0, 1'b0, a);
    cyc(1'b1, 32'h604, 32'h1, 32'h1, 32'h8, 3'd0, 1'b0, 1'b0, a);
    in_valid = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    q.delete();
    br_e = 0;
    mp_e = 0;
    chk_cleared();
    @(negedge clk);
    rst = 1'b0;
    idle(4);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
